spi_slave_if: RTL and testbench

- Serial-to-parallel SPI slave front end; sits directly upstream of the single-port RAM stage.
- Collects 10-bit MOSI frames and presents each as rx_data with a one-cycle rx_valid strobe.
- For read-data frames, waits for the RAM's tx_valid, then shifts the 8-bit tx_data back out on MISO.
- SPI mode 0, single clock domain: the master drives SS_n and MOSI synchronous to clk, so clk is the SPI serial clock.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_tx_shifter.sv | 45 ++++
 rtl/spi_slave_if.sv | 120 ++++++++++++
 tb/tb_spi_slave_if.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  localparam int SPI_FRAME_W = 10;
  localparam int SPI_DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    TX_WAIT   = 3'd5,
    TX_SHIFT  = 3'd6,
    DONE      = 3'd7
  } state_t;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serializer; done flags that the last bit is on sout.
module spi_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              sout,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sreg_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              sout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_reg <= '0;
      cnt_reg  <= '0;
      sout_reg <= 1'b0;
    end else if (clear) begin
      sreg_reg <= '0;
      cnt_reg  <= '0;
      sout_reg <= 1'b0;
    end else if (load) begin
      // MSB goes straight to the output; the rest waits in the register
      sout_reg <= data[DATA_W-1];
      sreg_reg <= {data[DATA_W-2:0], 1'b0};
      cnt_reg  <= '0;
    end else if (shift) begin
      sout_reg <= sreg_reg[DATA_W-1];
      sreg_reg <= {sreg_reg[DATA_W-2:0], 1'b0};
      cnt_reg  <= cnt_reg + 1'b1;
    end
  end

  assign sout = sout_reg;
  assign done = (cnt_reg == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: assembles 10-bit MOSI frames, returns RAM read data on MISO.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int FRAME_W     = SPI_FRAME_W,
  parameter int DATA_W      = SPI_DATA_W,
  parameter int TX_WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int BIT_W  = $clog2(FRAME_W);
  localparam int WAIT_W = $clog2(TX_WAIT_MAX + 1);

  state_t             state_reg;
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] rx_data_reg;
  logic               rx_valid_reg;
  logic [BIT_W-1:0]   bit_cnt_reg;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic               rd_addr_done_reg;

  logic tx_load, tx_shift, tx_clear, tx_done;

  assign tx_load  = (state_reg == TX_WAIT) && !SS_n && tx_valid;
  assign tx_shift = (state_reg == TX_SHIFT) && !SS_n && !tx_done;
  assign tx_clear = SS_n || ((state_reg == TX_SHIFT) && tx_done);

  spi_tx_shifter #(.DATA_W(DATA_W)) u_tx_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tx_clear),
    .load  (tx_load),
    .shift (tx_shift),
    .data  (tx_data),
    .sout  (MISO),
    .done  (tx_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      shift_reg        <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      bit_cnt_reg      <= '0;
      wait_cnt_reg     <= '0;
      rd_addr_done_reg <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      // Deselect beats everything, including a frame completing on this edge
      if (SS_n && (state_reg != IDLE)) begin
        state_reg    <= IDLE;
        bit_cnt_reg  <= '0;
        wait_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            bit_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            if (!SS_n) state_reg <= CHK_CMD;
          end
          CHK_CMD: begin
            shift_reg   <= {{(FRAME_W-1){1'b0}}, MOSI};
            bit_cnt_reg <= '0;
            if (MOSI == CMD_WR_ADDR[1])  state_reg <= WRITE;
            else if (rd_addr_done_reg)   state_reg <= READ_DATA;
            else                         state_reg <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            shift_reg <= {shift_reg[FRAME_W-2:0], MOSI};
            if (bit_cnt_reg == BIT_W'(FRAME_W - 2)) begin
              bit_cnt_reg  <= BIT_W'(FRAME_W - 1);
              rx_data_reg  <= {shift_reg[FRAME_W-2:0], MOSI};
              rx_valid_reg <= 1'b1;
              wait_cnt_reg <= '0;
              if (state_reg == READ_DATA) begin
                state_reg <= TX_WAIT;
              end else begin
                state_reg <= DONE;
                if (state_reg == READ_ADD) rd_addr_done_reg <= 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
          TX_WAIT: begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
            if (tx_valid) begin
              state_reg <= TX_SHIFT;
            end else if (wait_cnt_reg == WAIT_W'(TX_WAIT_MAX - 1)) begin
              state_reg        <= DONE;
              rd_addr_done_reg <= 1'b0;
            end
          end
          TX_SHIFT: begin
            if (tx_done) begin
              state_reg        <= DONE;
              rd_addr_done_reg <= 1'b0;
            end
          end
          DONE:    state_reg <= DONE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: frames, read-back, abort, timeout, async reset.
module tb_spi_slave_if;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;
  logic [9:0] frame;
  logic [7:0] exp_byte;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  spi_slave_if dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic ss, input logic mosi);
    @(negedge clk);
    SS_n = ss;
    MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  // Select edge, then nbits frame bits MSB first
  task automatic send_frame(input logic [9:0] f, input int nbits);
    tick(1'b0, 1'b0);
    for (int i = 9; i > 9 - nbits; i--) begin
      tick(1'b0, f[i]);
      if (i == 1) chk("early_strobe", rx_valid, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_miso", MISO, 1'b0);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_data", rx_data, 10'h000);
    chk("rst_state", dut.state_reg, IDLE);
    @(negedge clk) rst_n = 1'b1;

    // Write address
    frame = {CMD_WR_ADDR, 8'h05};
    send_frame(frame, 10);
    chk("wa_valid", rx_valid, 1'b1);
    chk("wa_data", rx_data, 10'h005);
    tick(1'b0, 1'b1);
    chk("wa_pulse", rx_valid, 1'b0);
    chk("wa_state", dut.state_reg, DONE);
    chk("wa_hold", rx_data, 10'h005);
    tick(1'b1, 1'b0);
    chk("wa_idle", dut.state_reg, IDLE);

    // Write data
    frame = {CMD_WR_DATA, 8'hAA};
    send_frame(frame, 10);
    chk("wd_valid", rx_valid, 1'b1);
    chk("wd_data", rx_data, 10'h1AA);
    tick(1'b0, 1'b0);
    chk("wd_pulse", rx_valid, 1'b0);
    chk("wd_rd", dut.rd_addr_done_reg, 1'b0);
    tick(1'b1, 1'b0);

    // Read address then read data with tx_valid two cycles late
    frame = {CMD_RD_ADDR, 8'h05};
    send_frame(frame, 10);
    chk("ra_data", rx_data, 10'h205);
    chk("ra_rd", dut.rd_addr_done_reg, 1'b1);
    chk("ra_state", dut.state_reg, DONE);
    tick(1'b1, 1'b0);
    chk("ra_rd_idle", dut.rd_addr_done_reg, 1'b1);
    frame = {CMD_RD_DATA, 8'h3C};
    send_frame(frame, 10);
    chk("rdd_cmd", rx_data[9:8], 2'b11);
    chk("rdd_state", dut.state_reg, TX_WAIT);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("rdd_miso_wait", MISO, 1'b0);
    exp_byte = 8'hAA;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = exp_byte;
    @(posedge clk);
    #1;
    chk("rdd_miso_b7", MISO, exp_byte[7]);
    tx_data = 8'h55;  // tx_valid left high: must be ignored in TX_SHIFT
    for (int i = 6; i >= 0; i--) begin
      tick(1'b0, 1'b0);
      chk($sformatf("rdd_miso_b%0d", i), MISO, exp_byte[i]);
    end
    tick(1'b0, 1'b0);
    chk("rdd_miso_end", MISO, 1'b0);
    chk("rdd_state_end", dut.state_reg, DONE);
    chk("rdd_rd_clr", dut.rd_addr_done_reg, 1'b0);
    tx_valid = 1'b0;
    tick(1'b1, 1'b0);

    // Abort after 5 bits, then a clean frame
    frame = {CMD_WR_DATA, 8'hF0};
    send_frame(frame, 5);
    tick(1'b1, 1'b0);
    chk("ab_valid", rx_valid, 1'b0);
    chk("ab_state", dut.state_reg, IDLE);
    chk("ab_hold", rx_data, 10'h33C);
    frame = {CMD_WR_ADDR, 8'hC3};
    send_frame(frame, 10);
    chk("ab_next_valid", rx_valid, 1'b1);
    chk("ab_next_data", rx_data, 10'h0C3);
    tick(1'b1, 1'b0);

    // Deselect on the completing edge discards the frame
    frame = 10'h155;
    send_frame(frame, 9);
    tick(1'b1, frame[0]);
    chk("pri_valid", rx_valid, 1'b0);
    chk("pri_hold", rx_data, 10'h0C3);
    chk("pri_state", dut.state_reg, IDLE);

    // Read timeout
    frame = {CMD_RD_ADDR, 8'h11};
    send_frame(frame, 10);
    tick(1'b1, 1'b0);
    frame = {CMD_RD_DATA, 8'h22};
    send_frame(frame, 10);
    chk("to_enter", dut.state_reg, TX_WAIT);
    for (int k = 1; k <= 14; k++) begin
      tick(1'b0, 1'b0);
      if (k == 14) begin
        chk("to_still_wait", dut.state_reg, TX_WAIT);
        chk("to_miso_wait", MISO, 1'b0);
      end
    end
    tick(1'b0, 1'b0);
    chk("to_state", dut.state_reg, DONE);
    chk("to_miso", MISO, 1'b0);
    chk("to_rd_clr", dut.rd_addr_done_reg, 1'b0);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick(1'b0, 1'b0);
    chk("to_late_valid", MISO, 1'b0);
    tx_valid = 1'b0;
    tick(1'b1, 1'b0);

    // Abort keeps rd_addr_done; async reset mid-transmit clears everything
    frame = {CMD_RD_ADDR, 8'h7E};
    send_frame(frame, 10);
    tick(1'b1, 1'b0);
    frame = {CMD_RD_ADDR, 8'h00};
    send_frame(frame, 3);
    tick(1'b1, 1'b0);
    chk("abort_keeps_rd", dut.rd_addr_done_reg, 1'b1);
    frame = {CMD_RD_DATA, 8'h01};
    send_frame(frame, 10);
    chk("rs_data_pre", rx_data, 10'h301);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h80;
    @(posedge clk);
    #1;
    chk("rs_miso_pre", MISO, 1'b1);
    tx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rs_miso", MISO, 1'b0);
    chk("rs_rd", dut.rd_addr_done_reg, 1'b0);
    chk("rs_data", rx_data, 10'h000);
    chk("rs_state", dut.state_reg, IDLE);
    @(negedge clk) rst_n = 1'b1;
    tick(1'b1, 1'b0);

    // Async reset during READ_ADD
    frame = {CMD_RD_ADDR, 8'hFF};
    send_frame(frame, 6);
    chk("rsa_pre", dut.state_reg, READ_ADD);
    #2 rst_n = 1'b0;
    #1;
    chk("rsa_state", dut.state_reg, IDLE);
    chk("rsa_rd", dut.rd_addr_done_reg, 1'b0);
    chk("rsa_valid", rx_valid, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
